// File: rtl/writeback.sv
// Writeback stage: formats load data, drives the register-file write port,
// reports traps through a RUN/FLUSH/HALT sequencer and counts retired instructions.
module writeback #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned EXW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipeline_in_valid,
    input  logic            nop_instr_in,
    input  logic [XLEN-1:0] PC_in,
    input  logic [4:0]      opcode_in,
    input  logic [2:0]      funct_in,
    input  logic [4:0]      rd_addr_in,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] mem_rd_data_in,
    input  logic [1:0]      addr_lsb_in,
    input  logic [EXW-1:0]  exception_in,
    input  logic            exception_in_valid,
    input  logic            trap_ack,
    output logic            rf_wr_enable,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic            trap_valid,
    output logic [EXW-1:0]  trap_cause,
    output logic [XLEN-1:0] trap_pc,
    output logic            flush_out,
    output logic [63:0]     instret
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [EXW-1:0] CAUSE_ILLEGAL    = EXW'(2);
    localparam logic [EXW-1:0] CAUSE_MISALIGNED = EXW'(4);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic            is_load;
    logic            writes_rd;
    logic            load_illegal;
    logic            load_misaligned;
    logic            local_exc;
    logic [EXW-1:0]  local_cause;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic            live;
    logic            take_trap;
    logic [EXW-1:0]  cause;
    logic            retire;
    logic            wr;
    logic [XLEN-1:0] wr_data;

    // Opcode decode and load-word alignment/extension.
    always_comb begin
        is_load         = (opcode_in == OPC_LOAD);
        writes_rd       = 1'b0;
        load_illegal    = 1'b0;
        load_misaligned = 1'b0;
        shifted         = mem_rd_data_in >> {addr_lsb_in, 3'b000};
        load_data       = shifted;

        case (opcode_in)
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP,
            OPC_LUI, OPC_JALR, OPC_JAL: writes_rd = 1'b1;
            default:                    writes_rd = 1'b0;
        endcase

        case (funct_in)
            3'b000: load_data = XLEN'($signed(shifted[7:0]));
            3'b001: begin
                load_data       = XLEN'($signed(shifted[15:0]));
                load_misaligned = addr_lsb_in[0];
            end
            3'b010: begin
                load_data       = XLEN'($signed(shifted[31:0]));
                load_misaligned = (addr_lsb_in != 2'b00);
            end
            3'b100: load_data = XLEN'(shifted[7:0]);
            3'b101: begin
                load_data       = XLEN'(shifted[15:0]);
                load_misaligned = addr_lsb_in[0];
            end
            default: load_illegal = 1'b1;
        endcase

        local_exc   = is_load && (load_illegal || load_misaligned);
        local_cause = load_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
    end

    // Slot qualification; an upstream exception outranks a locally detected one.
    always_comb begin
        live      = pipeline_in_valid && !nop_instr_in && (state == RUN);
        cause     = exception_in_valid ? exception_in : local_cause;
        take_trap = live && (exception_in_valid || local_exc);
        retire    = live && !(exception_in_valid || local_exc);
        wr        = retire && writes_rd && (rd_addr_in != 5'd0);
        wr_data   = is_load ? load_data : result_in;
    end

    // Trap sequencer next state.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (take_trap) state_next = FLUSH;
            FLUSH:   state_next = HALT;
            HALT:    if (trap_ack) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Registered write port, trap report, flush and retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_wr_enable <= 1'b0;
            rf_wr_addr   <= 5'd0;
            rf_wr_data   <= '0;
            trap_valid   <= 1'b0;
            trap_cause   <= '0;
            trap_pc      <= '0;
            flush_out    <= 1'b0;
            instret      <= 64'd0;
        end else begin
            rf_wr_enable <= wr;
            if (wr) begin
                rf_wr_addr <= rd_addr_in;
                rf_wr_data <= wr_data;
            end
            flush_out <= (state_next == FLUSH);
            if (take_trap) begin
                trap_valid <= 1'b1;
                trap_cause <= cause;
                trap_pc    <= PC_in;
            end else if ((state == HALT) && trap_ack) begin
                trap_valid <= 1'b0;
            end
            // Assigned every cycle so the counter always follows its own current value.
            instret <= instret + 64'(retire);
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage: load formatting, traps, halt/ack,
// retire counting and counter wrap, with hand-computed expectations.
module tb_writeback;

    localparam int unsigned XLEN = 32;
    localparam int unsigned EXW  = 4;

    localparam logic [4:0] OPC_LOAD = 5'b00000;
    localparam logic [4:0] OPC_OP   = 5'b01100;

    logic            clk;
    logic            reset;
    logic            pipeline_in_valid;
    logic            nop_instr_in;
    logic [XLEN-1:0] PC_in;
    logic [4:0]      opcode_in;
    logic [2:0]      funct_in;
    logic [4:0]      rd_addr_in;
    logic [XLEN-1:0] result_in;
    logic [XLEN-1:0] mem_rd_data_in;
    logic [1:0]      addr_lsb_in;
    logic [EXW-1:0]  exception_in;
    logic            exception_in_valid;
    logic            trap_ack;
    logic            rf_wr_enable;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic            trap_valid;
    logic [EXW-1:0]  trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            flush_out;
    logic [63:0]     instret;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_instret = 64'd0;

    writeback #(.XLEN(XLEN), .EXW(EXW)) dut (
        .clk(clk), .reset(reset),
        .pipeline_in_valid(pipeline_in_valid), .nop_instr_in(nop_instr_in),
        .PC_in(PC_in), .opcode_in(opcode_in), .funct_in(funct_in),
        .rd_addr_in(rd_addr_in), .result_in(result_in),
        .mem_rd_data_in(mem_rd_data_in), .addr_lsb_in(addr_lsb_in),
        .exception_in(exception_in), .exception_in_valid(exception_in_valid),
        .trap_ack(trap_ack),
        .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .flush_out(flush_out), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        pipeline_in_valid  = 1'b0;
        nop_instr_in       = 1'b0;
        PC_in              = '0;
        opcode_in          = 5'b11111;
        funct_in           = 3'b000;
        rd_addr_in         = 5'd0;
        result_in          = '0;
        mem_rd_data_in     = '0;
        addr_lsb_in        = 2'd0;
        exception_in       = '0;
        exception_in_valid = 1'b0;
        trap_ack           = 1'b0;
    endtask

    task automatic slot(input logic [4:0] opc, input logic [2:0] fn, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] mem, input logic [1:0] lsb,
                        input logic [31:0] pc);
        idle();
        pipeline_in_valid = 1'b1;
        opcode_in         = opc;
        funct_in          = fn;
        rd_addr_in        = rd;
        result_in         = res;
        mem_rd_data_in    = mem;
        addr_lsb_in       = lsb;
        PC_in             = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (rf_wr_enable !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'd0 ||
            trap_valid !== 1'b0 || trap_cause !== 4'd0 || trap_pc !== 32'd0 ||
            flush_out !== 1'b0 || instret !== 64'd0) begin
            failures++;
            $display("FAIL reset_state en=%b addr=%0d data=%h tv=%b tc=%0d tpc=%h fl=%b ir=%0d required all zero",
                     rf_wr_enable, rf_wr_addr, rf_wr_data, trap_valid, trap_cause, trap_pc, flush_out, instret);
        end
    endtask

    task automatic test_load_format();
        logic [2:0]  fn   [5] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010};
        logic [31:0] mem  [5] = '{32'h0000_8000, 32'hBEEF_1234, 32'h0000_8001, 32'hAB00_0000, 32'h1234_5678};
        logic [1:0]  lsb  [5] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0};
        logic [31:0] expd [5] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_00AB, 32'h1234_5678};
        for (int i = 0; i < 5; i++) begin
            slot(OPC_LOAD, fn[i], 5'(5 + i), 32'hDEAD_0000, mem[i], lsb[i], 32'h40);
            tick();
            exp_instret++;
            checks++;
            if (rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'(5 + i) || rf_wr_data !== expd[i] ||
                instret !== exp_instret) begin
                failures++;
                $display("FAIL load_fmt_%0d en=%b addr=%0d data=%h ir=%0d required 1/%0d/%h/%0d",
                         i, rf_wr_enable, rf_wr_addr, rf_wr_data, instret, 5 + i, expd[i], exp_instret);
            end
        end
        idle();
        tick();
        checks++;
        if (rf_wr_enable !== 1'b0) begin
            failures++;
            $display("FAIL write_one_cycle en=%b required 0", rf_wr_enable);
        end
    endtask

    task automatic test_trap_misaligned();
        slot(OPC_LOAD, 3'b010, 5'd8, 32'd0, 32'h1111_2222, 2'd2, 32'h100);
        tick();
        idle();
        checks++;
        if (rf_wr_enable !== 1'b0 || trap_valid !== 1'b1 || trap_cause !== 4'd4 ||
            trap_pc !== 32'h100 || flush_out !== 1'b1 || instret !== exp_instret) begin
            failures++;
            $display("FAIL lw_misaligned_trap en=%b tv=%b tc=%0d tpc=%h fl=%b ir=%0d required 0/1/4/100/1/%0d",
                     rf_wr_enable, trap_valid, trap_cause, trap_pc, flush_out, instret, exp_instret);
        end
        tick();
        checks++;
        if (flush_out !== 1'b0 || trap_valid !== 1'b1 || trap_cause !== 4'd4 || trap_pc !== 32'h100) begin
            failures++;
            $display("FAIL halt_hold fl=%b tv=%b tc=%0d tpc=%h required 0/1/4/100",
                     flush_out, trap_valid, trap_cause, trap_pc);
        end
    endtask

    task automatic test_halt_ack();
        for (int i = 0; i < 3; i++) begin
            slot(OPC_OP, 3'b000, 5'd9, 32'h0000_0077, 32'd0, 2'd0, 32'h200);
            tick();
            checks++;
            if (rf_wr_enable !== 1'b0 || instret !== exp_instret || trap_valid !== 1'b1) begin
                failures++;
                $display("FAIL halt_ignore_%0d en=%b ir=%0d tv=%b required 0/%0d/1",
                         i, rf_wr_enable, instret, trap_valid, exp_instret);
            end
        end
        idle();
        trap_ack = 1'b1;
        tick();
        checks++;
        if (trap_valid !== 1'b0 || rf_wr_enable !== 1'b0) begin
            failures++;
            $display("FAIL ack_clears tv=%b en=%b required 0/0", trap_valid, rf_wr_enable);
        end
        slot(OPC_OP, 3'b000, 5'd9, 32'h0000_0055, 32'd0, 2'd0, 32'h204);
        tick();
        exp_instret++;
        checks++;
        if (rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'd9 || rf_wr_data !== 32'h55 || instret !== exp_instret) begin
            failures++;
            $display("FAIL write_after_ack en=%b addr=%0d data=%h ir=%0d required 1/9/55/%0d",
                     rf_wr_enable, rf_wr_addr, rf_wr_data, instret, exp_instret);
        end
    endtask

    task automatic test_rd0_nop();
        slot(OPC_OP, 3'b000, 5'd0, 32'h1234, 32'd0, 2'd0, 32'h300);
        tick();
        exp_instret++;
        checks++;
        if (rf_wr_enable !== 1'b0 || instret !== exp_instret) begin
            failures++;
            $display("FAIL rd0_no_write en=%b ir=%0d required 0/%0d", rf_wr_enable, instret, exp_instret);
        end
        slot(OPC_OP, 3'b000, 5'd3, 32'h1234, 32'd0, 2'd0, 32'h304);
        nop_instr_in = 1'b1;
        tick();
        checks++;
        if (rf_wr_enable !== 1'b0 || instret !== exp_instret) begin
            failures++;
            $display("FAIL nop_ignored en=%b ir=%0d required 0/%0d", rf_wr_enable, instret, exp_instret);
        end
    endtask

    task automatic test_exc_priority();
        slot(OPC_LOAD, 3'b010, 5'd4, 32'd0, 32'd0, 2'd1, 32'h400);
        exception_in_valid = 1'b1;
        exception_in       = 4'd7;
        tick();
        idle();
        trap_ack = 1'b1;
        checks++;
        if (trap_valid !== 1'b1 || trap_cause !== 4'd7 || trap_pc !== 32'h400 || rf_wr_enable !== 1'b0 ||
            instret !== exp_instret) begin
            failures++;
            $display("FAIL upstream_priority tv=%b tc=%0d tpc=%h en=%b ir=%0d required 1/7/400/0/%0d",
                     trap_valid, trap_cause, trap_pc, rf_wr_enable, instret, exp_instret);
        end
        tick();
        checks++;
        if (trap_valid !== 1'b1 || flush_out !== 1'b0) begin
            failures++;
            $display("FAIL ack_in_flush_ignored tv=%b fl=%b required 1/0", trap_valid, flush_out);
        end
        tick();
        trap_ack = 1'b0;
        checks++;
        if (trap_valid !== 1'b0) begin
            failures++;
            $display("FAIL ack_in_halt tv=%b required 0", trap_valid);
        end
        slot(OPC_LOAD, 3'b011, 5'd4, 32'd0, 32'd0, 2'd0, 32'h500);
        tick();
        idle();
        checks++;
        if (trap_valid !== 1'b1 || trap_cause !== 4'd2 || trap_pc !== 32'h500 || flush_out !== 1'b1) begin
            failures++;
            $display("FAIL illegal_funct tv=%b tc=%0d tpc=%h fl=%b required 1/2/500/1",
                     trap_valid, trap_cause, trap_pc, flush_out);
        end
        tick();
        trap_ack = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            slot(OPC_OP, 3'b000, 5'(10 + i), 32'hA000_0000 + 32'(i), 32'd0, 2'd0, 32'h600);
            tick();
            exp_instret++;
            checks++;
            if (rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'(10 + i) ||
                rf_wr_data !== 32'hA000_0000 + 32'(i) || instret !== exp_instret) begin
                failures++;
                $display("FAIL back_to_back_%0d en=%b addr=%0d data=%h ir=%0d required 1/%0d/%h/%0d",
                         i, rf_wr_enable, rf_wr_addr, rf_wr_data, instret, 10 + i,
                         32'hA000_0000 + 32'(i), exp_instret);
            end
        end
        idle();
    endtask

    task automatic test_wrap_and_reset();
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        release dut.instret;
        slot(OPC_OP, 3'b000, 5'd14, 32'h0000_00EE, 32'd0, 2'd0, 32'h700);
        tick();
        exp_instret = 64'd0;
        checks++;
        if (instret !== exp_instret || rf_wr_enable !== 1'b1) begin
            failures++;
            $display("FAIL instret_wrap ir=%h en=%b required 0/1", instret, rf_wr_enable);
        end
        slot(OPC_LOAD, 3'b001, 5'd15, 32'd0, 32'd0, 2'd1, 32'h800);
        tick();
        idle();
        checks++;
        if (flush_out !== 1'b1 || trap_valid !== 1'b1) begin
            failures++;
            $display("FAIL enter_flush fl=%b tv=%b required 1/1", flush_out, trap_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rf_wr_enable !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'd0 ||
            trap_valid !== 1'b0 || trap_cause !== 4'd0 || trap_pc !== 32'd0 ||
            flush_out !== 1'b0 || instret !== 64'd0) begin
            failures++;
            $display("FAIL reset_in_flush en=%b addr=%0d data=%h tv=%b tc=%0d tpc=%h fl=%b ir=%0d required all zero",
                     rf_wr_enable, rf_wr_addr, rf_wr_data, trap_valid, trap_cause, trap_pc, flush_out, instret);
        end
        @(negedge clk);
        reset = 1'b1;
        slot(OPC_OP, 3'b000, 5'd16, 32'h0000_0123, 32'd0, 2'd0, 32'h900);
        tick();
        idle();
        checks++;
        if (rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'd16 || rf_wr_data !== 32'h123 ||
            instret !== 64'd1 || flush_out !== 1'b0) begin
            failures++;
            $display("FAIL run_after_reset en=%b addr=%0d data=%h ir=%0d fl=%b required 1/16/123/1/0",
                     rf_wr_enable, rf_wr_addr, rf_wr_data, instret, flush_out);
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_load_format();
        test_trap_misaligned();
        test_halt_ack();
        test_rd0_nop();
        test_exc_priority();
        test_back_to_back();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter: XLEN, 32, data and PC width.
REQ-002 Parameter: EXW, 4, exception cause width.
REQ-003 clk  in  1  single clock, all state on rising edge; one clock; reset is asynchronous and active-low.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 pipeline_in_valid  in  1  memory-stage slot valid.
REQ-006 nop_instr_in  in  1  slot is a bubble/NOP.
REQ-007 PC_in  in  XLEN  PC of slot.
REQ-008 opcode_in  in  5  instr[6:2]; funct_in  in  3  instr[14:12].
REQ-009 rd_addr_in  in  5  destination register.
REQ-010 result_in  in  XLEN  ALU/link result; mem_rd_data_in  in  XLEN  raw load word; addr_lsb_in  in  2  load address bits [1:0].
REQ-011 exception_in  in  EXW, exception_in_valid  in  1  upstream exception.
REQ-012 trap_ack  in  1  trap handler accepted trap.
REQ-013 rf_wr_enable  out  1, rf_wr_addr  out  5, rf_wr_data  out  XLEN  register-file write port.
REQ-014 trap_valid  out  1, trap_cause  out  EXW, trap_pc  out  XLEN  trap report.
REQ-015 flush_out  out  1  pipeline flush request.
REQ-016 instret  out  64  retired-instruction counter.

Function
REQ-017 A slot is live when pipeline_in_valid=1, nop_instr_in=0 and FSM is RUN; otherwise it is ignored entirely.
REQ-018 Writing opcodes: LOAD 00000, OP-IMM 00100, AUIPC 00101, OP 01100, LUI 01101, JALR 11001, JAL 11011; all others write nothing.
REQ-019 Load formatting: shift mem_rd_data_in right by 8*addr_lsb_in; funct 000 sign-extend byte, 001 sign-extend half, 010 word, 100 zero-extend byte, 101 zero-extend half.
REQ-020 Non-load writing opcodes write result_in unchanged.
REQ-021 Local exceptions: load funct 011/110/111 -> cause 2; LH/LHU with addr_lsb_in[0]=1 or LW with addr_lsb_in!=0 -> cause 4.
REQ-022 Priority: exception_in_valid over local exception; any exception suppresses the write and the retire.
REQ-023 Register write is registered: rf_wr_* asserted exactly one cycle after a live writing slot, for one cycle; rd_addr_in=0 never asserts rf_wr_enable.
REQ-024 instret increments by 1 in the cycle after each live, non-excepting slot; wraps 2^64-1 -> 0.
REQ-025 FSM states RUN, FLUSH, HALT.
REQ-026 RUN -> FLUSH on a live excepting slot; next cycle trap_valid=1, trap_cause, trap_pc=PC_in captured, flush_out=1.
REQ-027 FLUSH -> HALT after exactly one cycle; flush_out=1 only in FLUSH.
REQ-028 HALT: trap_valid, trap_cause, trap_pc held; all input slots ignored; rf_wr_enable=0.
REQ-029 HALT -> RUN on trap_ack=1; trap_valid clears the same edge; trap_ack in RUN or FLUSH ignored.
REQ-030 Back-to-back live slots every cycle sustained in RUN with no bubbles inserted.

Reset
REQ-031 reset=0 asynchronously forces: FSM RUN, rf_wr_enable=0, rf_wr_addr=0, rf_wr_data=0, trap_valid=0, trap_cause=0, trap_pc=0, flush_out=0, instret=0.
REQ-032 reset asserted in FLUSH or HALT abandons the trap; first edge after release behaves as RUN.

Verification
REQ-033 LB, mem_rd_data_in=0x00008000, addr_lsb=1, rd=5 -> next cycle rf_wr_enable=1, addr 5, data 0xFFFFFF80; instret +1.
REQ-034 LHU, data 0xBEEF1234, addr_lsb=2 -> rf_wr_data 0x0000BEEF; LW with addr_lsb=2, PC 0x100 -> no write, trap_cause 4, trap_pc 0x100, flush_out one cycle, HALT.
REQ-035 In HALT, 3 live OP slots then trap_ack -> no writes, instret unchanged, trap_valid drops, next slot writes.
REQ-036 OP slot rd=0, then nop_instr_in=1 slot rd=3 -> no writes; instret +1 then +0.
REQ-037 exception_in_valid=1 cause 7 on misaligned LW -> trap_cause 7.
REQ-038 Force instret=0xFFFFFFFFFFFFFFFF, retire one -> 0; assert reset mid-FLUSH -> all outputs zero immediately, RUN after release.
